// File: rtl/dcache_responder_if.sv
// Backing-memory bus between the data cache and its memory.
// master: cache side, slave: memory side.
interface dcache_responder_if;
  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  modport master (
    output mem_enable_o,
    output mem_write_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_enable_o,
    input  mem_write_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i,
    output mem_ack_i
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped one-word-line write-through data cache.
// Loads hit in zero cycles; misses and all stores go to memory.
module dcache_responder #(
  parameter int LINES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] p_addr_i,
  input  logic [31:0] p_data_i,
  input  logic        p_MemRead_i,
  input  logic        p_MemWrite_i,
  output logic [31:0] p_data_o,
  output logic        p_stall_o,
  dcache_responder_if.master mem
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    WR_DONE
  } state_t;

  state_t          state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES];
  logic [29:0]     addr_q;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] lat_idx;
  logic [TW-1:0] lat_tag;
  logic          hit;
  logic          lat_hit;
  logic          is_store;
  logic          is_load;
  logic          unused_addr;

  assign req_idx = p_addr_i[2+IW-1:2];
  assign req_tag = p_addr_i[31:2+IW];
  assign lat_idx = addr_q[IW-1:0];
  assign lat_tag = addr_q[29:IW];

  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // A store wins when both request strobes are high.
  assign is_store = p_MemWrite_i;
  assign is_load  = p_MemRead_i && !p_MemWrite_i;

  assign unused_addr = &{1'b0, p_addr_i[1:0]};

  always_comb begin
    p_stall_o = 1'b0;
    p_data_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (is_store) begin
          p_stall_o = 1'b1;
        end else if (is_load) begin
          if (hit) p_data_o = data_q[req_idx];
          else     p_stall_o = 1'b1;
        end
      end
      RD_MISS,
      WR_THRU: p_stall_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      valid_q          <= '0;
      addr_q           <= '0;
      mem.mem_enable_o <= 1'b0;
      mem.mem_write_o  <= 1'b0;
      mem.mem_addr_o   <= '0;
      mem.mem_data_o   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_store) begin
            addr_q           <= p_addr_i[31:2];
            mem.mem_enable_o <= 1'b1;
            mem.mem_write_o  <= 1'b1;
            mem.mem_addr_o   <= {p_addr_i[31:2], 2'b00};
            mem.mem_data_o   <= p_data_i;
            state_q          <= WR_THRU;
          end else if (is_load && !hit) begin
            addr_q           <= p_addr_i[31:2];
            mem.mem_enable_o <= 1'b1;
            mem.mem_write_o  <= 1'b0;
            mem.mem_addr_o   <= {p_addr_i[31:2], 2'b00};
            state_q          <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem.mem_ack_i) begin
            valid_q[lat_idx] <= 1'b1;
            tag_q[lat_idx]   <= lat_tag;
            data_q[lat_idx]  <= mem.mem_data_i;
            mem.mem_enable_o <= 1'b0;
            state_q          <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem.mem_ack_i) begin
            // No write-allocate: only a resident line is refreshed.
            if (lat_hit) data_q[lat_idx] <= mem.mem_data_o;
            mem.mem_enable_o <= 1'b0;
            mem.mem_write_o  <= 1'b0;
            state_q          <= WR_DONE;
          end
        end
        WR_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder with a word-level cache model
// and a randomized-latency backing memory.
module tb_dcache_responder;

  localparam int LINES = 32;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          stall;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } mt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_rd;
  logic        p_wr;
  logic        p_stall;

  int errors = 0;
  int checks = 0;
  int completions = 0;
  int stall_cnt = 0;
  bit mon_en = 1'b0;
  bit mem_auto = 1'b0;

  sb_t sbq[$];
  mt_t mtq[$];
  logic [31:0] bmem [int unsigned];
  longint resident [LINES];

  dcache_responder_if mem_if ();

  dcache_responder #(.LINES(LINES)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .p_addr_i     (p_addr),
    .p_data_i     (p_wdata),
    .p_MemRead_i  (p_rd),
    .p_MemWrite_i (p_wr),
    .p_data_o     (p_rdata),
    .p_stall_o    (p_stall),
    .mem          (mem_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(int unsigned w);
    if (bmem.exists(w)) return bmem[w];
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < LINES; i++) resident[i] = -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Completion monitor: a held request finishes on its first unstalled cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_rd || p_wr) begin
          if (p_stall) begin
            stall_cnt++;
          end else begin
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty: unexpected completion at %0t", $time);
            end else begin
              e = sbq.pop_front();
              check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
              if (e.is_load) check("load_data", p_rdata, e.data);
            end
            stall_cnt = 0;
            completions++;
          end
        end else begin
          check("idle_stall", {31'b0, p_stall}, 32'd0);
          check("idle_data", p_rdata, 32'd0);
        end
      end
    end
  end

  // Backing memory: acks after the requested number of enabled cycles.
  initial begin
    mt_t cur;
    bit  active;
    int  cnt;
    active = 1'b0;
    cnt = 0;
    mem_if.mem_ack_i = 1'b0;
    mem_if.mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_if.mem_ack_i = 1'b0;
        mem_if.mem_data_i = $urandom;
        if (!active) begin
          if (mem_if.mem_enable_o) begin
            if (mtq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mem_spurious: addr %h", mem_if.mem_addr_o);
            end else begin
              cur = mtq.pop_front();
              check("mem_write", {31'b0, mem_if.mem_write_o}, {31'b0, cur.wr});
              check("mem_addr", mem_if.mem_addr_o, cur.addr);
              if (cur.wr) check("mem_wdata", mem_if.mem_data_o, cur.data);
              active = 1'b1;
              cnt = 1;
            end
          end
        end else begin
          cnt++;
          check("mem_hold_en", {31'b0, mem_if.mem_enable_o}, 32'd1);
          check("mem_hold_addr", mem_if.mem_addr_o, cur.addr);
        end
        if (active && cnt >= cur.lat) begin
          mem_if.mem_ack_i = 1'b1;
          if (!cur.wr) mem_if.mem_data_i = cur.data;
          active = 1'b0;
        end
      end
    end
  end

  task automatic do_op(bit rd, bit wr, logic [31:0] addr,
                       logic [31:0] data, int lat);
    int unsigned w;
    int idx;
    int start;
    int t;
    sb_t e;
    mt_t m;
    w = addr >> 2;
    idx = int'(w % LINES);
    if (wr) begin
      m = '{1'b1, {addr[31:2], 2'b00}, data, lat};
      mtq.push_back(m);
      bmem[w] = data;
      e = '{1'b0, 32'd0, 1 + lat};
    end else begin
      e.is_load = 1'b1;
      e.data = memval(w);
      if (resident[idx] == longint'(w)) begin
        e.stall = 0;
      end else begin
        e.stall = 1 + lat;
        m = '{1'b0, {addr[31:2], 2'b00}, e.data, lat};
        mtq.push_back(m);
        resident[idx] = longint'(w);
      end
    end
    sbq.push_back(e);
    p_addr = addr;
    p_wdata = data;
    p_rd = rd;
    p_wr = wr;
    start = completions;
    t = 0;
    while (completions == start && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (completions == start) begin
      checks++;
      errors++;
      $display("FAIL timeout: op at addr %h never completed", addr);
      finish_run();
    end
    #1;
    p_rd = 1'b0;
    p_wr = 1'b0;
    p_addr = $urandom;
    p_wdata = $urandom;
  endtask

  initial begin
    #600000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    int k;
    logic [31:0] a;
    rst = 1'b1;
    p_rd = 1'b0;
    p_wr = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_enable", {31'b0, mem_if.mem_enable_o}, 32'd0);
    check("rst_mem_write", {31'b0, mem_if.mem_write_o}, 32'd0);
    check("rst_mem_addr", mem_if.mem_addr_o, 32'd0);
    check("rst_mem_data", mem_if.mem_data_o, 32'd0);
    check("rst_stall", {31'b0, p_stall}, 32'd0);
    check("rst_data", p_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_auto = 1'b1;
    mon_en = 1'b1;

    bmem[32'h40 >> 2] = 32'hDEADBEEF;
    do_op(1, 0, 32'h40, 0, 3);
    do_op(0, 1, 32'h40, 32'h12345678, 2);
    do_op(1, 0, 32'h40, 0, 1);
    do_op(0, 1, 32'h80, 32'hCAFEF00D, 2);
    do_op(1, 0, 32'h80, 0, 2);
    do_op(1, 0, 32'hC0, 0, 1);
    do_op(1, 0, 32'h40, 0, 2);
    do_op(1, 1, 32'h44, 32'h0BADBEEF, 1);
    do_op(1, 0, 32'h44, 0, 1);
    do_op(1, 0, 32'h44, 0, 1);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = 32'(($urandom_range(0, 3) * LINES + $urandom_range(0, LINES - 1)) * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      if (k < 6)      do_op(1, 0, a, $urandom, $urandom_range(1, 4));
      else if (k < 9) do_op(0, 1, a, $urandom, $urandom_range(1, 4));
      else            do_op(1, 1, a, $urandom, $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    mon_en = 1'b0;
    mem_auto = 1'b0;
    mem_if.mem_ack_i = 1'b0;
    p_addr = 32'h3F00;
    p_rd = 1'b1;
    @(negedge clk);
    check("abort_miss_stall", {31'b0, p_stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_mem_enable", {31'b0, mem_if.mem_enable_o}, 32'd1);
    check("abort_mem_write", {31'b0, mem_if.mem_write_o}, 32'd0);
    check("abort_mem_addr", mem_if.mem_addr_o, 32'h3F00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p_rd = 1'b0;
    @(negedge clk);
    check("abort_enable_low", {31'b0, mem_if.mem_enable_o}, 32'd0);
    check("abort_stall_low", {31'b0, p_stall}, 32'd0);
    mem_if.mem_data_i = 32'h5555AAAA;
    mem_if.mem_ack_i = 1'b1;
    @(posedge clk);
    #1;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack_enable", {31'b0, mem_if.mem_enable_o}, 32'd0);
    check("late_ack_write", {31'b0, mem_if.mem_write_o}, 32'd0);
    @(posedge clk);
    #1;
    clear_model();
    sbq.delete();
    mtq.delete();
    stall_cnt = 0;
    mem_auto = 1'b1;
    mon_en = 1'b1;
    do_op(1, 0, 32'h3F00, 0, 2);
    do_op(1, 0, 32'h3F00, 0, 2);
    repeat (2) @(posedge clk);
    #1;
    finish_run();
  end

endmodule
